// File: rtl/AHB_package.sv
`default_nettype none
// =============================================================================
// Module  : AHB_package
// Brief   : Shared encodings, address map and default-slave states for AHB_Gen.
// Revision: 1.0
// =============================================================================
package AHB_package;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int HREADYOUT_BIT = 33;
   localparam int HRESP_BIT     = 32;
   localparam int HRDATA_LSB    = 0;

   // Address map sized for the largest supported SLAVE_NUM; entries beyond it are ignored.
   localparam int SLV_MAX = 8;
   localparam logic [31:0] SLV_BASE [SLV_MAX] = '{
      32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
      32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000
   };
   localparam logic [31:0] SLV_MASK [SLV_MAX] = '{default: 32'hF000_0000};

   typedef enum logic [1:0] {
      DF_IDLE = 2'd0,
      DF_ERR1 = 2'd1,
      DF_ERR2 = 2'd2
   } df_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// =============================================================================
// Module  : ahb_default_slave
// Brief   : Answers unmapped active transfers with the two-cycle ERROR response.
// Revision: 1.0
// =============================================================================
module ahb_default_slave
   import AHB_package::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_hready,
   input  logic i_unmapped,
   output logic o_hready,
   output logic o_err_active
);

   df_state_t r_state;
   logic      r_hready;
   logic      r_err_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= DF_IDLE;
         r_hready     <= 1'b1;
         r_err_active <= 1'b0;
      end else begin
         case (r_state)
            DF_IDLE: begin
               if (i_hready && i_unmapped) begin
                  r_state      <= DF_ERR1;
                  r_hready     <= 1'b0;
                  r_err_active <= 1'b1;
               end
            end
            DF_ERR1: begin
               r_state      <= DF_ERR2;
               r_hready     <= 1'b1;
               r_err_active <= 1'b1;
            end
            DF_ERR2: begin
               if (i_hready && i_unmapped) begin
                  r_state      <= DF_ERR1;
                  r_hready     <= 1'b0;
                  r_err_active <= 1'b1;
               end else begin
                  r_state      <= DF_IDLE;
                  r_hready     <= 1'b1;
                  r_err_active <= 1'b0;
               end
            end
            default: begin
               r_state      <= DF_IDLE;
               r_hready     <= 1'b1;
               r_err_active <= 1'b0;
            end
         endcase
      end
   end

   assign o_hready     = r_hready;
   assign o_err_active = r_err_active;

endmodule
`default_nettype wire

// File: rtl/ahb_master_decoder.sv
`default_nettype none
// =============================================================================
// Module  : ahb_master_decoder
// Brief   : Per-master address decode, data-phase select capture and response mux.
// Revision: 1.0
// =============================================================================
module ahb_master_decoder
   import AHB_package::*;
#(
   parameter int SLAVE_NUM  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int PAY_LOAD   = 34
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   output logic [SLAVE_NUM-1:0]  hsel,
   output logic [SLAVE_NUM-1:0]  resp_sel,
   input  logic [PAY_LOAD-1:0]   mux_payload,
   output logic                  HREADY,
   output logic                  HRESP,
   output logic [31:0]           HRDATA
);

   logic [SLAVE_NUM-1:0] w_hit;
   logic                 w_any_hit;
   logic                 w_unmapped;
   logic                 w_dflt_hready;
   logic                 w_err_active;
   logic [SLAVE_NUM-1:0] r_resp_sel;

   // Priority decode: the lowest-indexed matching region claims the address.
   always_comb begin
      w_hit     = '0;
      w_any_hit = 1'b0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (!w_any_hit &&
             ((HADDR & SLV_MASK[i][ADDR_WIDTH-1:0]) == SLV_BASE[i][ADDR_WIDTH-1:0])) begin
            w_hit[i]  = 1'b1;
            w_any_hit = 1'b1;
         end
      end
   end

   assign hsel       = HTRANS[1] ? w_hit : '0;
   assign w_unmapped = HTRANS[1] && !w_any_hit;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_resp_sel <= '0;
      end else if (HREADY) begin
         r_resp_sel <= hsel;
      end
   end

   assign resp_sel = r_resp_sel;

   ahb_default_slave u_default_slave (
      .clk          (HCLK),
      .rst_n        (HRESETn),
      .i_hready     (HREADY),
      .i_unmapped   (w_unmapped),
      .o_hready     (w_dflt_hready),
      .o_err_active (w_err_active)
   );

   // An unmapped transfer captures a zero select, so the error path and the
   // slave mux path can never both own the data phase.
   always_comb begin
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      HRDATA = '0;
      if (w_err_active) begin
         HREADY = w_dflt_hready;
         HRESP  = HRESP_ERROR;
      end else if (|r_resp_sel) begin
         HREADY = mux_payload[HREADYOUT_BIT];
         HRESP  = mux_payload[HRESP_BIT];
         HRDATA = mux_payload[HRDATA_LSB +: 32];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_decoder.sv
`default_nettype none
// =============================================================================
// Module  : tb_ahb_master_decoder
// Brief   : Directed scoreboard bench for ahb_master_decoder.
// Revision: 1.0
// =============================================================================
module tb_ahb_master_decoder;

   logic        HCLK;
   logic        HRESETn;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [3:0]  hsel;
   logic [3:0]  resp_sel;
   logic [33:0] mux_payload;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;

   ahb_master_decoder #(
      .SLAVE_NUM  (4),
      .ADDR_WIDTH (32),
      .PAY_LOAD   (34)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .hsel        (hsel),
      .resp_sel    (resp_sel),
      .mux_payload (mux_payload),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      int          waits;
      logic [31:0] data;
      logic [3:0]  hsel;
   } stim_t;

   typedef struct {
      logic [3:0]  rsel;
      logic        hresp;
      logic [31:0] rdata;
      int          waits;
      int          id;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          chk_cnt = 0;
   int          fail_cnt = 0;
   int          w_seen = 0;
   bit          mon_en = 1'b0;
   bit          cur_map = 1'b0;
   int          cur_w = 0;
   logic [31:0] cur_d = 32'h0;
   stim_t       tbl[11];
   stim_t       idle_s;
   stim_t       s_tmp;

   localparam logic [33:0] GARBAGE = {1'b0, 1'b1, 32'hDEAD_BEEF};

   // Drives one address phase, holds it until accepted, and plays the slave side.
   task automatic run_item(input stim_t s, input bit push, input int id);
      bit   acc;
      bit   done;
      int   budget;
      exp_t e;
      HADDR  = s.addr;
      HTRANS = s.trans;
      budget = 0;
      done   = 1'b0;
      while (!done) begin
         @(negedge HCLK);
         chk_cnt++;
         if (hsel !== s.hsel) begin
            fail_cnt++;
            $display("FAIL hsel item %0d: got %b expected %b", id, hsel, s.hsel);
         end
         acc = HREADY;
         @(posedge HCLK);
         #1;
         if (acc) begin
            done = 1'b1;
            if (s.hsel != 4'b0) begin
               cur_map = 1'b1;
               cur_w   = s.waits;
               cur_d   = s.data;
            end else begin
               cur_map = 1'b0;
            end
            if (push) begin
               if (s.hsel != 4'b0)  e = '{s.hsel, 1'b0, s.data, s.waits, id};
               else if (s.trans[1]) e = '{4'b0, 1'b1, 32'h0, 1, id};
               else                 e = '{4'b0, 1'b0, 32'h0, 0, id};
               q.push_back(e);
            end
         end else begin
            if (cur_w > 0) cur_w--;
            budget++;
            if (budget > 30) begin
               chk_cnt++;
               fail_cnt++;
               $display("FAIL accept_timeout item %0d: HREADY stuck at %b, required 1", id, HREADY);
               done = 1'b1;
            end
         end
         mux_payload = cur_map ? {(cur_w == 0), 1'b0, cur_d} : GARBAGE;
      end
   endtask

   // Scoreboard monitor: checks every data-phase cycle against the queue head.
   always @(negedge HCLK) begin
      if (mon_en) begin
         if (q.size() == 0) begin
            chk_cnt++;
            if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
               fail_cnt++;
               $display("FAIL idle_resp: got HREADY=%b HRESP=%b required 1/0", HREADY, HRESP);
            end
         end else begin
            mon_e = q[0];
            if (HREADY === 1'b0) begin
               w_seen++;
               chk_cnt++;
               if (HRESP !== mon_e.hresp || resp_sel !== mon_e.rsel) begin
                  fail_cnt++;
                  $display("FAIL wait item %0d: got HRESP=%b resp_sel=%b required %b/%b",
                           mon_e.id, HRESP, resp_sel, mon_e.hresp, mon_e.rsel);
               end
               if (w_seen > 40) begin
                  chk_cnt++;
                  fail_cnt++;
                  $display("FAIL wait_timeout item %0d: %0d waits, required %0d", mon_e.id, w_seen, mon_e.waits);
                  void'(q.pop_front());
                  w_seen = 0;
               end
            end else begin
               chk_cnt++;
               if (w_seen != mon_e.waits) begin
                  fail_cnt++;
                  $display("FAIL waits item %0d: got %0d required %0d", mon_e.id, w_seen, mon_e.waits);
               end
               chk_cnt++;
               if (HRESP !== mon_e.hresp) begin
                  fail_cnt++;
                  $display("FAIL hresp item %0d: got %b required %b", mon_e.id, HRESP, mon_e.hresp);
               end
               chk_cnt++;
               if (HRDATA !== mon_e.rdata) begin
                  fail_cnt++;
                  $display("FAIL hrdata item %0d: got %h required %h", mon_e.id, HRDATA, mon_e.rdata);
               end
               chk_cnt++;
               if (resp_sel !== mon_e.rsel) begin
                  fail_cnt++;
                  $display("FAIL resp_sel item %0d: got %b required %b", mon_e.id, resp_sel, mon_e.rsel);
               end
               void'(q.pop_front());
               w_seen = 0;
            end
         end
      end
   end

   task automatic check1(input string name, input logic [31:0] got, input logic [31:0] req);
      chk_cnt++;
      if (got !== req) begin
         fail_cnt++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && q.size() != 0; k++) run_item(idle_s, 1'b0, 99);
      chk_cnt++;
      if (q.size() != 0) begin
         fail_cnt++;
         $display("FAIL drain: %0d responses outstanding, required 0", q.size());
         q.delete();
      end
      run_item(idle_s, 1'b0, 99);
   endtask

   initial begin
      tbl[0]  = '{32'h2000_0010, 2'b10, 2, 32'hA5A5_0002, 4'b0100};
      tbl[1]  = '{32'h4000_0000, 2'b10, 0, 32'h0,         4'b0000};
      tbl[2]  = '{32'h4000_0000, 2'b00, 0, 32'h0,         4'b0000};
      tbl[3]  = '{32'h5000_0000, 2'b01, 0, 32'h0,         4'b0000};
      tbl[4]  = '{32'h0000_0100, 2'b10, 0, 32'h1111_0000, 4'b0001};
      tbl[5]  = '{32'h3000_0104, 2'b11, 0, 32'h3333_0003, 4'b1000};
      tbl[6]  = '{32'h1000_0000, 2'b10, 1, 32'h2222_0001, 4'b0010};
      tbl[7]  = '{32'h8000_0000, 2'b10, 0, 32'h0,         4'b0000};
      tbl[8]  = '{32'hF000_0000, 2'b10, 0, 32'h0,         4'b0000};
      tbl[9]  = '{32'h1000_0000, 2'b00, 0, 32'h0,         4'b0000};
      tbl[10] = '{32'h3FFF_FFFC, 2'b10, 0, 32'h4444_0004, 4'b1000};
      idle_s  = '{32'h0000_0000, 2'b00, 0, 32'h0,         4'b0000};

      // Reset with a live mapped NONSEQ on the bus and a not-ready payload.
      HRESETn     = 1'b0;
      HADDR       = 32'h1000_0000;
      HTRANS      = 2'b10;
      mux_payload = GARBAGE;
      repeat (2) @(negedge HCLK);
      check1("reset_hready",   {31'b0, HREADY},   32'h1);
      check1("reset_hresp",    {31'b0, HRESP},    32'h0);
      check1("reset_hrdata",   HRDATA,            32'h0);
      check1("reset_resp_sel", {28'b0, resp_sel}, 32'h0);
      check1("reset_hsel",     {28'b0, hsel},     32'h2);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      mon_en  = 1'b1;

      for (int i = 0; i < 11; i++) run_item(tbl[i], 1'b1, i);
      drain();

      // Reset pulse while the default slave sits in its first ERROR cycle.
      mon_en = 1'b0;
      s_tmp  = '{32'h6000_0000, 2'b10, 0, 32'h0, 4'b0000};
      run_item(s_tmp, 1'b0, 50);
      @(negedge HCLK);
      check1("err1_hready", {31'b0, HREADY}, 32'h0);
      check1("err1_hresp",  {31'b0, HRESP},  32'h1);
      #2;
      HRESETn = 1'b0;
      HTRANS  = 2'b00;
      #1;
      check1("midrst_hready",   {31'b0, HREADY},   32'h1);
      check1("midrst_hresp",    {31'b0, HRESP},    32'h0);
      check1("midrst_hrdata",   HRDATA,            32'h0);
      check1("midrst_resp_sel", {28'b0, resp_sel}, 32'h0);
      @(posedge HCLK);
      #1;
      HRESETn     = 1'b1;
      cur_map     = 1'b0;
      cur_w       = 0;
      mux_payload = GARBAGE;
      q.delete();
      w_seen      = 0;
      mon_en      = 1'b1;

      s_tmp = '{32'h0000_0200, 2'b10, 1, 32'h5555_0005, 4'b0001};
      run_item(s_tmp, 1'b1, 60);
      drain();

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
